// File: rtl/attn_out_collector_if.sv
// Beat stream from the attention top into the collector, and the drain stream
// from the collector to its consumer.
//   master : attention-top / consumer side (drives beats, rd_ready)
//   slave  : collector side (accepts beats, drives rd_valid/rd_addr/rd_data/drain_done)
interface attn_out_collector_if;
    logic         in_valid;
    logic [1:0]   in_row;
    logic [4:0]   in_group;
    logic [127:0] in_data;
    logic         attn_done;
    logic         rd_valid;
    logic         rd_ready;
    logic [6:0]   rd_addr;
    logic [127:0] rd_data;
    logic         drain_done;

    modport master (
        output in_valid, in_row, in_group, in_data, attn_done, rd_ready,
        input  rd_valid, rd_addr, rd_data, drain_done
    );

    modport slave (
        input  in_valid, in_row, in_group, in_data, attn_done, rd_ready,
        output rd_valid, rd_addr, rd_data, drain_done
    );
endinterface

// File: rtl/attn_out_collector.sv
// attn_out_collector: captures the 4-head attention output stream into a 128x128b
// single-port SRAM at {row, group}, tracks coverage with a written bitmap, and on
// request drains the SRAM in address order through a small credit-based FIFO.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin collection (rising edge, honoured in idle only)
//   bus (slave)       in_* beat stream + attn_done; rd_* drain stream + drain_done
//   O_mem_addr/wen/din SRAM command (write in collect, read in drain)
//   O_mem_out         SRAM read data, valid READ_LAT cycles after the address
//   full              all 128 words written
//   rd_start          begin drain, honoured only when collection has finished
//   err               sticky {overrun, missing, dup}
// Optional feature: define ATTN_OUT_NAN_CHECK_EN to add nan_flag / nan_addr.
module attn_out_collector #(
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = READ_LAT + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    attn_out_collector_if.slave   bus,
    output logic [6:0]            O_mem_addr,
    output logic                  O_mem_wen,
    output logic [127:0]          O_mem_din,
    input  logic [127:0]          O_mem_out,
    output logic                  full,
    input  logic                  rd_start,
    output logic [2:0]            err
`ifdef ATTN_OUT_NAN_CHECK_EN
    ,
    output logic                  nan_flag,
    output logic [6:0]            nan_addr
`endif
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {CIdle, CCollect, CFull, CDrain} state_t;

    state_t        state;
    logic          start_q;
    logic [127:0]  bitmap;
    logic [7:0]    wr_cnt;
    logic [7:0]    rd_ptr;
    logic [7:0]    pop_cnt;
    logic          full_q;
    logic          drain_done_q;
    logic [2:0]    err_q;

    // Read pipeline: one valid/address pair per outstanding SRAM read.
    logic [READ_LAT-1:0] pipe_v;
    logic [6:0]          pipe_a [READ_LAT];

    logic [6:0]    fifo_a [FIFO_DEPTH];
    logic [127:0]  fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] fifo_cnt;

    logic          start_edge;
    logic [6:0]    wr_addr;
    logic          beat;
    logic          bit_set;
    logic [7:0]    cnt_after;
    logic [31:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign start_edge = start & ~start_q;
    assign wr_addr    = {bus.in_row, bus.in_group};
    assign beat       = (state == CCollect) && bus.in_valid;
    assign bit_set    = bitmap[wr_addr];
    assign cnt_after  = wr_cnt + {7'd0, beat & ~bit_set};

    // Credits: FIFO slots are reserved at issue time so returning data always fits.
    always_comb begin
        occupancy = 32'(fifo_cnt);
        for (int unsigned i = 0; i < READ_LAT; i++) begin
            occupancy = occupancy + 32'(pipe_v[i]);
        end
    end

    assign issue = (state == CDrain) && !rd_ptr[7] && (occupancy < FIFO_DEPTH);
    assign push  = pipe_v[READ_LAT-1];
    assign pop   = (fifo_cnt != '0) && bus.rd_ready;

    assign O_mem_wen  = beat;
    assign O_mem_addr = beat ? wr_addr : (issue ? rd_ptr[6:0] : 7'd0);
    assign O_mem_din  = beat ? bus.in_data : 128'd0;

    assign bus.rd_valid   = (fifo_cnt != '0);
    assign bus.rd_addr    = fifo_a[rptr];
    assign bus.rd_data    = fifo_d[rptr];
    assign bus.drain_done = drain_done_q;
    assign full           = full_q;
    assign err            = err_q;

`ifdef ATTN_OUT_NAN_CHECK_EN
    logic       nan_flag_q;
    logic [6:0] nan_addr_q;
    logic       beat_nan;

    // fp32 NaN: exponent all ones with a non-zero mantissa.
    always_comb begin
        beat_nan = 1'b0;
        for (int l = 0; l < 4; l++) begin
            if (bus.in_data[32*l+23 +: 8] == 8'hFF && bus.in_data[32*l +: 23] != 23'd0) begin
                beat_nan = 1'b1;
            end
        end
    end

    assign nan_flag = nan_flag_q;
    assign nan_addr = nan_addr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CIdle;
            start_q      <= 1'b0;
            bitmap       <= '0;
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            pop_cnt      <= '0;
            full_q       <= 1'b0;
            drain_done_q <= 1'b0;
            err_q        <= '0;
            pipe_v       <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) pipe_a[i] <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_a[i] <= '0;
                fifo_d[i] <= '0;
            end
            wptr         <= '0;
            rptr         <= '0;
            fifo_cnt     <= '0;
`ifdef ATTN_OUT_NAN_CHECK_EN
            nan_flag_q   <= 1'b0;
            nan_addr_q   <= '0;
`endif
        end else begin
            start_q      <= start;
            drain_done_q <= 1'b0;

            for (int unsigned i = READ_LAT - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
            pipe_v[0] <= issue;
            pipe_a[0] <= rd_ptr[6:0];

            if (push) begin
                fifo_a[wptr] <= pipe_a[READ_LAT-1];
                fifo_d[wptr] <= O_mem_out;
                wptr         <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            case (state)
                CIdle: begin
                    if (start_edge) begin
                        state      <= CCollect;
                        bitmap     <= '0;
                        wr_cnt     <= '0;
                        err_q      <= '0;
`ifdef ATTN_OUT_NAN_CHECK_EN
                        nan_flag_q <= 1'b0;
                        nan_addr_q <= '0;
`endif
                    end
                end
                CCollect: begin
                    if (beat) begin
                        bitmap[wr_addr] <= 1'b1;
                        wr_cnt          <= cnt_after;
                        if (bit_set) err_q[0] <= 1'b1;
`ifdef ATTN_OUT_NAN_CHECK_EN
                        if (beat_nan && !nan_flag_q) begin
                            nan_flag_q <= 1'b1;
                            nan_addr_q <= wr_addr;
                        end
`endif
                    end
                    // The beat arriving with attn_done still counts toward completion.
                    if (cnt_after == 8'd128 || bus.attn_done) begin
                        state  <= CFull;
                        full_q <= (cnt_after == 8'd128);
                        if (cnt_after != 8'd128) err_q[1] <= 1'b1;
                    end
                end
                CFull: begin
                    if (rd_start) begin
                        state   <= CDrain;
                        full_q  <= 1'b0;
                        rd_ptr  <= '0;
                        pop_cnt <= '0;
                    end
                end
                CDrain: begin
                    if (issue) rd_ptr <= rd_ptr + 1'b1;
                    if (pop) begin
                        pop_cnt <= pop_cnt + 1'b1;
                        if (pop_cnt == 8'd127) begin
                            drain_done_q <= 1'b1;
                            bitmap       <= '0;
                            state        <= CIdle;
                        end
                    end
                end
                default: state <= CIdle;
            endcase

            if (bus.in_valid && state != CCollect) err_q[2] <= 1'b1;
        end
    end
endmodule
